// File: rtl/tetris_pkg.sv
// Shared command encoding between the move-command generator and the game executioner.
package tetris_pkg;

    typedef enum logic [1:0] {
        CMD_LEFT   = 2'd0,
        CMD_RIGHT  = 2'd1,
        CMD_ROTATE = 2'd2
    } command_t;

endpackage

// File: rtl/move_command_generator.sv
// Button front end (sync, debounce, auto-repeat) feeding a framed move_clk strobe
// that hands one command at a time to the game executioner.
module move_command_generator
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned DAS_CYCLES      = 800000,
    parameter int unsigned ARR_CYCLES      = 200000,
    parameter int unsigned STROBE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    output command_t   move,
    output logic       move_valid,
    output logic       move_clk,
    output logic [7:0] issued_count
);

    localparam int unsigned NBTN    = 3;
    localparam int unsigned IDX_L   = 0;
    localparam int unsigned IDX_R   = 1;
    localparam int unsigned IDX_ROT = 2;
    localparam int unsigned DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned RPW     = $clog2(REP_MAX + 1);
    localparam int unsigned STW     = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t          state;
    logic [NBTN-1:0] raw_c;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] deb;
    logic [NBTN-1:0] deb_q;
    logic [DBW-1:0]  db_cnt [NBTN];
    logic [NBTN-1:0] press_c;

    logic [RPW-1:0]  rep_cnt [2];
    logic [1:0]      rep_armed;
    logic [1:0]      rep_evt_c;
    logic            lr_both_c;

    logic [NBTN-1:0] pend;
    logic [NBTN-1:0] evt_c;
    logic [NBTN-1:0] win_oh_c;
    logic [NBTN-1:0] clr_c;
    command_t        win_c;
    logic [STW-1:0]  st_cnt;

    assign raw_c     = {btn_rotate, btn_right, btn_left};
    assign press_c   = deb & ~deb_q;
    assign lr_both_c = deb[IDX_L] & deb[IDX_R];

    // Two-flop synchronizer and per-button debounce; level flips after a full run of disagreeing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Auto-repeat fires first at DAS after the press, then every ARR; armed marks the ARR phase
    always_comb begin
        rep_evt_c = '0;
        for (int i = 0; i < 2; i++) begin
            if (deb[i] && !lr_both_c) begin
                rep_evt_c[i] = rep_armed[i] ? (rep_cnt[i] == RPW'(ARR_CYCLES))
                                            : (rep_cnt[i] == RPW'(DAS_CYCLES));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_armed <= '0;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!deb[i] || lr_both_c) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b0;
                end else if (rep_evt_c[i]) begin
                    rep_cnt[i]   <= RPW'(1);
                    rep_armed[i] <= 1'b1;
                end else if (rep_cnt[i] != RPW'(REP_MAX)) begin
                    rep_cnt[i] <= rep_cnt[i] + RPW'(1);
                end
            end
        end
    end

    // Fixed-priority arbitration: rotate, then left, then right
    always_comb begin
        evt_c    = press_c | {1'b0, rep_evt_c};
        win_oh_c = '0;
        win_c    = CMD_RIGHT;
        if (pend[IDX_ROT]) begin
            win_oh_c[IDX_ROT] = 1'b1;
            win_c             = CMD_ROTATE;
        end else if (pend[IDX_L]) begin
            win_oh_c[IDX_L] = 1'b1;
            win_c           = CMD_LEFT;
        end else if (pend[IDX_R]) begin
            win_oh_c[IDX_R] = 1'b1;
        end
        clr_c = (state == ST_IDLE) ? win_oh_c : '0;
    end

    // A new event in the clearing cycle re-arms the flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= '0;
        else        pend <= (pend & ~clr_c) | evt_c;
    end

    // Strobe framing: SETUP presents the command, then move_clk high and low for STROBE_CYCLES each
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            move         <= CMD_LEFT;
            move_valid   <= 1'b0;
            move_clk     <= 1'b0;
            issued_count <= '0;
            st_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    move_valid <= 1'b0;
                    move_clk   <= 1'b0;
                    if (pend != '0) begin
                        state        <= ST_SETUP;
                        move         <= win_c;
                        move_valid   <= 1'b1;
                        issued_count <= issued_count + 8'd1;
                    end
                end
                ST_SETUP: begin
                    state    <= ST_HIGH;
                    move_clk <= 1'b1;
                    st_cnt   <= '0;
                end
                ST_HIGH: begin
                    if (st_cnt == STW'(STROBE_CYCLES - 1)) begin
                        state    <= ST_LOW;
                        move_clk <= 1'b0;
                        st_cnt   <= '0;
                    end else begin
                        st_cnt <= st_cnt + STW'(1);
                    end
                end
                ST_LOW: begin
                    if (st_cnt == STW'(STROBE_CYCLES - 1)) begin
                        state      <= ST_IDLE;
                        move_valid <= 1'b0;
                        st_cnt     <= '0;
                    end else begin
                        st_cnt <= st_cnt + STW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_command_generator.sv
// Scoreboard bench: planned button waveforms go through a timing model that queues
// expected strobes; a monitor pops and checks each move_clk rise.
module tb_move_command_generator;
    import tetris_pkg::*;

    localparam int DB  = 4;
    localparam int DAS = 20;
    localparam int ARR = 8;
    localparam int S   = 2;

    typedef struct {
        command_t cmd;
        int       cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rotate = 1'b0;
    command_t   move;
    logic       move_valid;
    logic       move_clk;
    logic [7:0] issued_count;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_issued = 0;
    int         last_rise = -1;
    exp_t       sb[$];
    logic [2:0] wave[$];

    move_command_generator #(
        .DEBOUNCE_CYCLES(DB),
        .DAS_CYCLES     (DAS),
        .ARR_CYCLES     (ARR),
        .STROBE_CYCLES  (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_rotate  (btn_rotate),
        .move        (move),
        .move_valid  (move_valid),
        .move_clk    (move_clk),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every move_clk rise must match the head of the expected queue
    logic     prev_mclk = 1'b0;
    logic     prev_valid = 1'b0;
    command_t held_move = CMD_LEFT;
    int       drop_at = -1;
    exp_t     mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            prev_mclk  = 1'b0;
            prev_valid = 1'b0;
            drop_at    = -1;
        end else begin
            if (move_clk && !prev_mclk) begin
                last_rise = cyc;
                chk("valid_before_rise", int'(prev_valid), 1);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", int'(move), -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("move_cmd", int'(move), int'(mon_e.cmd));
                    chk("rise_cycle", cyc, mon_e.cyc);
                end
                held_move = move;
                drop_at   = cyc + 2 * S;
            end
            if (!move_clk && prev_mclk) begin
                chk("move_held", int'(move), int'(held_move));
                chk("valid_held", int'(move_valid), 1);
            end
            if (cyc == drop_at) chk("valid_drop", int'(move_valid), 0);
            prev_mclk  = move_clk;
            prev_valid = move_valid;
        end
    end

    function automatic bit rawv(input int x, input int i);
        logic [2:0] w;
        if (x < 0 || x >= wave.size()) return 1'b0;
        w = wave[x];
        return w[i];
    endfunction

    task automatic add_seg(input int i, input int start, input int len);
        logic [2:0] w;
        while (wave.size() < start + len) wave.push_back(3'b000);
        for (int x = start; x < start + len; x++) begin
            w = wave[x];
            w[i] = 1'b1;
            wave[x] = w;
        end
    endtask

    // Reference: a level flips once D consecutive synchronized samples disagree with it;
    // events set per-command flags; an idle issuer serves rotate > left > right every 2S+2 cycles.
    task automatic plan(input int base);
        int         n;
        bit   [2:0] deb[];
        bit   [2:0] ev[];
        bit   [2:0] prev;
        bit   [2:0] cur;
        bit   [2:0] pend;
        bit         mis;
        bit         solo;
        bit         solo_prev[2];
        int         start[2];
        int         k;
        int         idle_at;
        int         idx;
        command_t   c;
        n = wave.size() + 80;
        deb = new[n];
        ev  = new[n];
        solo_prev[0] = 0; solo_prev[1] = 0;
        start[0] = 0; start[1] = 0;
        for (int t = 0; t < n; t++) begin
            prev = (t == 0) ? 3'b000 : deb[t-1];
            cur  = prev;
            for (int i = 0; i < 3; i++) begin
                mis = 1'b1;
                for (int j = 0; j < DB; j++) if (rawv(t - 3 - j, i) == prev[i]) mis = 1'b0;
                if (mis) cur[i] = ~prev[i];
            end
            deb[t] = cur;
            ev[t]  = cur & ~prev;
            for (int i = 0; i < 2; i++) begin
                solo = cur[i] && !(cur[0] && cur[1]);
                if (solo && !solo_prev[i]) start[i] = t;
                if (solo) begin
                    k = t - start[i];
                    if (k == DAS || (k > DAS && ((k - DAS) % ARR) == 0)) ev[t][i] = 1'b1;
                end
                solo_prev[i] = solo;
            end
        end
        pend = 3'b000;
        idle_at = 0;
        for (int t = 0; t < n; t++) begin
            if (t > 0) pend = pend | ev[t-1];
            if (t >= idle_at && pend != 3'b000) begin
                if (pend[2])      begin idx = 2; c = CMD_ROTATE; end
                else if (pend[0]) begin idx = 0; c = CMD_LEFT;   end
                else              begin idx = 1; c = CMD_RIGHT;  end
                pend[idx] = 1'b0;
                sb.push_back('{c, base + t + 2});
                exp_issued = (exp_issued + 1) & 255;
                idle_at = t + 2 * S + 2;
            end
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        sb.delete();
        repeat (2 * S + DB + 10) @(posedge clk);
        #1;
        chk({name, "_count"}, int'(issued_count), exp_issued);
    endtask

    task automatic run_scenario(input string name, output int base);
        @(posedge clk); #1;
        base = cyc;
        plan(base);
        for (int x = 0; x < wave.size(); x++) begin
            {btn_rotate, btn_right, btn_left} = wave[x];
            @(posedge clk); #1;
        end
        {btn_rotate, btn_right, btn_left} = 3'b000;
        drain(name);
    endtask

    initial begin
        int base;
        int s0;
        int r;
        int t;
        int h;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(move_valid), 0);
        chk("rst_clk", int'(move_clk), 0);
        chk("rst_move", int'(move), int'(CMD_LEFT));
        chk("rst_count", int'(issued_count), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Single rotate press
        s0 = exp_issued;
        wave.delete(); add_seg(2, 0, 10);
        run_scenario("t1", base);
        chk("t1_rise", last_rise, base + 9);
        chk("t1_total", int'(issued_count), (s0 + 1) & 255);

        // Bouncing left plus a too-short pulse
        s0 = exp_issued;
        wave.delete();
        for (int x = 0; x < 20; x += 4) add_seg(0, x, 2);
        add_seg(0, 32, 3);
        run_scenario("t2", base);
        chk("t2_total", int'(issued_count), s0 & 255);

        // Held right with auto-repeat
        s0 = exp_issued;
        wave.delete(); add_seg(1, 0, 60);
        run_scenario("t3", base);
        chk("t3_total", int'(issued_count), (s0 + 6) & 255);
        chk("t3_last_rise", last_rise, base + 61);

        // All three together, left+right held: no repeats
        s0 = exp_issued;
        wave.delete(); add_seg(0, 0, 60); add_seg(1, 0, 60); add_seg(2, 0, 60);
        run_scenario("t4", base);
        chk("t4_total", int'(issued_count), (s0 + 3) & 255);
        chk("t4_last_rise", last_rise, base + 21);

        // Dense presses on all buttons: flags coalesce while the issuer is busy
        wave.delete();
        for (int x = 0; x < 48; x += 8) begin
            add_seg(2, x, 4); add_seg(0, x + 2, 4); add_seg(1, x + 4, 4);
        end
        run_scenario("t5", base);

        // Reset during HIGH, left held across reset release
        wave.delete(); add_seg(2, 0, 6);
        @(posedge clk); #1;
        base = cyc;
        plan(base);
        for (int x = 0; x < wave.size(); x++) begin
            {btn_rotate, btn_right, btn_left} = wave[x];
            @(posedge clk); #1;
        end
        btn_rotate = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_clk_before_reset", int'(move_clk), 1);
        btn_left = 1'b1;
        reset = 1'b0;
        #1;
        chk("t6_abort_clk", int'(move_clk), 0);
        chk("t6_abort_valid", int'(move_valid), 0);
        chk("t6_abort_count", int'(issued_count), 0);
        sb.delete();
        exp_issued = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        r = cyc;
        sb.push_back('{CMD_LEFT, r + 9});
        exp_issued = 1;
        repeat (7) @(posedge clk);
        #1;
        chk("t6_valid_r7", int'(move_valid), 0);
        @(posedge clk); #1;
        chk("t6_valid_r8", int'(move_valid), 1);
        chk("t6_move_r8", int'(move), int'(CMD_LEFT));
        repeat (2) @(posedge clk);
        #1;
        btn_left = 1'b0;
        drain("t6");

        // Randomized button activity
        for (int sc = 0; sc < 6; sc++) begin
            wave.delete();
            for (int i = 0; i < 3; i++) begin
                t = int'($urandom_range(0, 10));
                while (t < 120) begin
                    h = int'($urandom_range(1, 40));
                    add_seg(i, t, h);
                    t = t + h + int'($urandom_range(1, 30));
                end
            end
            run_scenario("rnd", base);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
